// File: rtl/mux9_mac_sequencer.sv
// Steps a 9:1 operand mux, multiply-accumulates each tap against its weight (Q8.8),
// and returns the saturated Q8.8 pre-activation through a valid/ready handshake.
module mux9_mac_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_IN   = 9,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  len,
  input  logic              in_stall,
  input  logic [DATA_W-1:0] mux_data,
  input  logic [DATA_W-1:0] weight_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state;
  logic        [SEL_W-1:0]   n_taps;
  logic        [SEL_W-1:0]   len_eff;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic        [DATA_W-1:0]  sat;
  logic                      last_tap;

  // Out-of-range lengths fall back to the full nine taps.
  assign len_eff = (len == '0 || len > SEL_W'(N_IN)) ? SEL_W'(N_IN) : len;

  assign prod     = $signed(mux_data) * $signed(weight_in);
  assign acc_sum  = acc + {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
  assign shifted  = acc_sum >>> FRAC;
  assign last_tap = (sel == n_taps - SEL_W'(1));

  // Fits when every bit above the result sign bit matches it; otherwise clamp by sign.
  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (!(&shifted[ACC_W-1:DATA_W-1]) && (|shifted[ACC_W-1:DATA_W-1])) begin
      sat = shifted[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}} : {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      sel       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      n_taps    <= SEL_W'(N_IN);
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            n_taps <= len_eff;
            acc    <= '0;
            sel    <= '0;
            busy   <= 1'b1;
            state  <= StRun;
          end
        end
        StRun: begin
          if (!in_stall) begin
            acc <= acc_sum;
            if (last_tap) begin
              result    <= sat;
              sel       <= '0;
              out_valid <= 1'b1;
              state     <= StDone;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux9_mac_sequencer.sv
// Bench for mux9_mac_sequencer: directed vector table, hand-written stall/back-pressure/reset
// sequences, and randomized transactions against an arithmetic reference model.
module tb_mux9_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        in_stall;
  logic [15:0] mux_data;
  logic [15:0] weight_in;
  logic [3:0]  sel;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  logic [15:0] dmem [9];
  logic [15:0] wmem [9];

  int tests = 0;
  int fails = 0;

  mux9_mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_stall  (in_stall),
    .mux_data  (mux_data),
    .weight_in (weight_in),
    .sel       (sel),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mux and weight store addressed by sel.
  always_comb begin
    mux_data  = 16'h0;
    weight_in = 16'h0;
    if (sel < 4'd9) begin
      mux_data  = dmem[sel];
      weight_in = wmem[sel];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_n(input logic [3:0] l);
    return (l == 4'd0 || l > 4'd9) ? 9 : int'(l);
  endfunction

  // Reference: exact integer dot product, floor-divide by 256, clamp to signed 16 bits.
  function automatic logic [15:0] model(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++)
      s += longint'($signed(dmem[i])) * longint'($signed(wmem[i]));
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic fill(input logic [15:0] d, input logic [15:0] w);
    for (int i = 0; i < 9; i++) begin
      dmem[i] = d;
      wmem[i] = w;
    end
  endtask

  task automatic run_txn(input logic [3:0] l, input int stall_pct, input int stall_sel,
                         input int stall_cnt, output int cycles, output int taken,
                         output int sel_err, output logic [15:0] res, output bit to);
    int rem;
    rem = stall_cnt;
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1 start = 1'b0;
    cycles  = 0;
    taken   = 0;
    sel_err = 0;
    to      = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (cycles > 200) begin
        to = 1'b1;
        break;
      end
      if (32'(sel) != taken || !busy) sel_err++;
      in_stall = ($urandom_range(99) < stall_pct) || (32'(sel) == stall_sel && rem > 0);
      if (in_stall && 32'(sel) == stall_sel && rem > 0) rem--;
      @(posedge clk);
      cycles++;
      if (!in_stall) taken++;
    end
    in_stall = 1'($urandom_range(1));
    res = result;
  endtask

  task automatic accept(input int hold, input logic [15:0] exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(exp_res));
      chk("hold_busy", 32'(busy), 32'd1);
      out_ready = 1'b0;
      start     = 1'b1;
      len       = 4'($urandom_range(15));
    end
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("accept_valid", 32'(out_valid), 32'd0);
    chk("accept_busy", 32'(busy), 32'd0);
    chk("accept_sel", 32'(sel), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("start_on_accept_ignored", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  l;
    logic [15:0] d;
    logic [15:0] w;
    int          n;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          cyc, tk, se;
    logic [15:0] r;
    bit          to;
    int          wd;

    vecs[0] = '{4'd9,  16'h0100, 16'h0100, 9, 16'h0900};
    vecs[1] = '{4'd1,  16'hFF00, 16'h0200, 1, 16'hFE00};
    vecs[2] = '{4'd1,  16'h0001, 16'hFFFF, 1, 16'hFFFF};
    vecs[3] = '{4'd9,  16'h7FFF, 16'h7FFF, 9, 16'h7FFF};
    vecs[4] = '{4'd9,  16'h8000, 16'h7FFF, 9, 16'h8000};
    vecs[5] = '{4'd0,  16'h0100, 16'h0100, 9, 16'h0900};
    vecs[6] = '{4'd12, 16'h0100, 16'h0100, 9, 16'h0900};
    vecs[7] = '{4'd4,  16'hFE80, 16'h0180, 4, 16'hF700};

    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    in_stall  = 1'b0;
    out_ready = 1'b0;
    fill(16'h0, 16'h0);
    #12;
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      fill(vecs[i].d, vecs[i].w);
      run_txn(vecs[i].l, 0, -1, 0, cyc, tk, se, r, to);
      chk("vec_timeout", 32'(to), 32'd0);
      chk("vec_taps", 32'(tk), 32'(vecs[i].n));
      chk("vec_latency", 32'(cyc), 32'(vecs[i].n));
      chk("vec_sel_seq", 32'(se), 32'd0);
      chk("vec_result", 32'(r), 32'(vecs[i].res));
      accept(0, vecs[i].res);
    end

    // Two-cycle stall at tap 1 of a three-tap run, then five cycles of back-pressure.
    fill(16'h0100, 16'h0100);
    run_txn(4'd3, 0, 1, 2, cyc, tk, se, r, to);
    chk("stall_timeout", 32'(to), 32'd0);
    chk("stall_taps", 32'(tk), 32'd3);
    chk("stall_latency", 32'(cyc), 32'd5);
    chk("stall_sel_seq", 32'(se), 32'd0);
    chk("stall_result", 32'(r), 32'h0300);
    accept(5, 16'h0300);

    // Asynchronous reset mid-run at sel 4.
    fill(16'h0100, 16'h0100);
    @(negedge clk);
    start = 1'b1;
    len   = 4'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wd = 0;
    while (sel != 4'd4 && wd < 50) begin
      @(negedge clk);
      wd++;
    end
    chk("reach_sel4", 32'(sel), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'd2, 0, -1, 0, cyc, tk, se, r, to);
    chk("post_rst_timeout", 32'(to), 32'd0);
    chk("post_rst_result", 32'(r), 32'h0200);
    chk("post_rst_latency", 32'(cyc), 32'd2);
    accept(1, 16'h0200);

    // Randomized transactions with random stalls and back-pressure.
    for (int t = 0; t < 25; t++) begin
      logic [3:0]  l;
      logic [15:0] e;
      for (int i = 0; i < 9; i++) begin
        dmem[i] = 16'($urandom);
        wmem[i] = (t % 3 == 0) ? 16'($urandom_range(65535)) : 16'($urandom_range(1023));
      end
      l = 4'($urandom_range(15));
      e = model(exp_n(l));
      run_txn(l, 30, -1, 0, cyc, tk, se, r, to);
      chk("rnd_timeout", 32'(to), 32'd0);
      chk("rnd_taps", 32'(tk), 32'(exp_n(l)));
      chk("rnd_sel_seq", 32'(se), 32'd0);
      chk("rnd_result", 32'(r), 32'(e));
      accept(int'($urandom_range(3)), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
